countdown_timer: RTL

- Loadable down-counter/timer. It is the counterpart of the up-counter (`counter`): it counts from a loaded value down to zero and flags terminal count.
- The load value is accepted over a valid/ready handshake. The block then decrements on `en` and asserts `tc` on reaching zero.
- Supports one-shot or auto-reload operation.
- Sits beside `counter` in the example design as a programmable interval/timeout source.

---
 rtl/countdown_pkg.sv | 13 +
 rtl/countdown_timer_prescaler.sv | 40 ++++
 rtl/countdown_timer.sv | 119 +++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and constants for the countdown_timer block.
// Provides the FSM state encoding and the prescaler upper bound.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cd_state_t;

    localparam int CD_MAX_PRESCALE = 255;

endpackage

// File: rtl/countdown_timer_prescaler.sv
// cd_prescaler: modulo-PRESCALE enable divider for countdown_timer.
// Ports: clk, rst (sync, active-high), clr (restart), en (advance),
//        tick (counter sits at PRESCALE-1, i.e. last cycle of a period).
module cd_prescaler
    import countdown_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(PRESCALE - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot / auto-reload modes.
// Ports: clk, rst (sync, active-high); load_valid/load_value/load_ready
//        handshake with auto_reload mode select; en decrement enable;
//        count, tc (terminal count), busy (running).
// Optional: define COUNTDOWN_PRESCALE_EN to act once per PRESCALE enabled
//           cycles (cd_prescaler); otherwise PRESCALE is unused.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             auto_reload,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    if (PRESCALE < 1 || PRESCALE > CD_MAX_PRESCALE) begin : g_bad_prescale
        $error("countdown_timer: PRESCALE out of range 1..255");
    end

    cd_state_t        state_q;
    cd_state_t        state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             mode_q;
    logic             mode_d;

    logic             accept;
    logic             at_zero;
    logic             tick;
    logic             act;

    assign load_ready = (state_q != RUN);
    assign accept     = load_valid && load_ready;
    assign at_zero    = (count_q == '0);

`ifdef COUNTDOWN_PRESCALE_EN
    logic pre_en;

    assign pre_en = (state_q == RUN) && en;

    cd_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (pre_en),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // One count/reload/finish action per qualified enabled cycle.
    assign act = en && tick;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    count_d  = load_value;
                    reload_d = load_value;
                    mode_d   = auto_reload;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (act) begin
                    if (!at_zero) begin
                        count_d = count_q - 1'b1;
                    end else if (mode_q) begin
                        count_d = reload_q;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
        end
    end

    // tc decodes straight from registered state so it is seen with zero
    // extra latency once count reaches 0.
    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign tc    = busy && at_zero && tick;

endmodule
